audio_mixer: RTL and testbench



---
 rtl/audio_mixer_pkg.sv | 23 ++
 rtl/audio_mix_sat.sv | 23 ++
 rtl/audio_mixer.sv | 164 ++++++++++++++++
 tb/tb_audio_mixer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_mixer_pkg.sv
// Shared types and constants for the time-multiplexed stereo mixer.
// The optional clip counter is enabled by defining AUDIO_MIXER_CLIP_COUNT_EN.
package audio_mixer_pkg;

   localparam logic [1:0] PAN_OFF  = 2'd0;
   localparam logic [1:0] PAN_L    = 2'd1;
   localparam logic [1:0] PAN_R    = 2'd2;
   localparam logic [1:0] PAN_BOTH = 2'd3;

   // Gain is Q1.3, so a gain of 8 passes the sample through unchanged.
   localparam int UNIT_GAIN = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SAT   = 2'd2
   } mix_state_e;

   function automatic int acc_width(input int in_w, input int gain_w, input int num_ch);
      return in_w + gain_w + $clog2(num_ch);
   endfunction

endpackage

// File: rtl/audio_mix_sat.sv
// Scales an accumulator back to output range (drop Q1.3 fraction and the
// IN_W/OUT_W difference) and saturates to all-ones, flagging a clip.
module audio_mix_sat
   import audio_mixer_pkg::*;
#(
   parameter int ACC_W = 22,
   parameter int IN_W  = 16,
   parameter int OUT_W = 16
) (
   input  logic [ACC_W-1:0] acc_i,
   output logic [OUT_W-1:0] sat_o,
   output logic             clip_o
);

   localparam int SH = $clog2(UNIT_GAIN) + IN_W - OUT_W;

   logic [ACC_W-1:0] v;

   assign v      = acc_i >> SH;
   assign clip_o = |v[ACC_W-1:OUT_W];
   assign sat_o  = clip_o ? {OUT_W{1'b1}} : v[OUT_W-1:0];

endmodule

// File: rtl/audio_mixer.sv
// Stereo mixer: snapshots NUM_CH channels on sample_ce, accumulates one
// channel per clock, then saturates. Clip counter under AUDIO_MIXER_CLIP_COUNT_EN.
module audio_mixer
   import audio_mixer_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int IN_W   = 16,
   parameter int OUT_W  = 16,
   parameter int GAIN_W = 4
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   input  logic                     sample_ce,
   input  logic [NUM_CH*IN_W-1:0]   ch_in,
   input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
   input  logic [NUM_CH*2-1:0]      ch_pan,
   output logic [OUT_W-1:0]         audio_l,
   output logic [OUT_W-1:0]         audio_r,
   output logic                     out_valid,
   output logic                     busy,
   output logic                     overrun,
   output logic [15:0]              clip_cnt,
   output mix_state_e               dbg_state
);

   localparam int ACC_W  = acc_width(IN_W, GAIN_W, NUM_CH);
   localparam int PROD_W = IN_W + GAIN_W;
   localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   mix_state_e         state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [ACC_W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic [IN_W-1:0]    snap_in_q [NUM_CH];
   logic [IN_W-1:0]    snap_in_d [NUM_CH];
   logic [GAIN_W-1:0]  snap_gain_q [NUM_CH];
   logic [GAIN_W-1:0]  snap_gain_d [NUM_CH];
   logic [1:0]         snap_pan_q [NUM_CH];
   logic [1:0]         snap_pan_d [NUM_CH];
   logic [OUT_W-1:0]   audio_l_q, audio_l_d, audio_r_q, audio_r_d;
   logic               out_valid_q, out_valid_d;
   logic               overrun_q, overrun_d;
   logic [PROD_W-1:0]  prod;
   logic [1:0]         cur_pan;
   logic [OUT_W-1:0]   sat_l, sat_r;
   logic               clip_l, clip_r;

   assign prod    = PROD_W'(snap_in_q[idx_q]) * PROD_W'(snap_gain_q[idx_q]);
   assign cur_pan = snap_pan_q[idx_q];

   audio_mix_sat #(.ACC_W(ACC_W), .IN_W(IN_W), .OUT_W(OUT_W)) u_sat_l (
      .acc_i (acc_l_q),
      .sat_o (sat_l),
      .clip_o(clip_l)
   );

   audio_mix_sat #(.ACC_W(ACC_W), .IN_W(IN_W), .OUT_W(OUT_W)) u_sat_r (
      .acc_i (acc_r_q),
      .sat_o (sat_r),
      .clip_o(clip_r)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_l_d     = acc_l_q;
      acc_r_d     = acc_r_q;
      snap_in_d   = snap_in_q;
      snap_gain_d = snap_gain_q;
      snap_pan_d  = snap_pan_q;
      audio_l_d   = audio_l_q;
      audio_r_d   = audio_r_q;
      out_valid_d = 1'b0;
      // A strobe is only honoured in IDLE; any other state (including SAT) is an overrun.
      overrun_d   = overrun_q | (sample_ce && (state_q != IDLE));
      case (state_q)
         IDLE: begin
            if (sample_ce) begin
               for (int i = 0; i < NUM_CH; i++) begin
                  snap_in_d[i]   = ch_in[i*IN_W +: IN_W];
                  snap_gain_d[i] = ch_gain[i*GAIN_W +: GAIN_W];
                  snap_pan_d[i]  = ch_pan[i*2 +: 2];
               end
               acc_l_d = '0;
               acc_r_d = '0;
               idx_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if ((cur_pan == PAN_L) || (cur_pan == PAN_BOTH)) acc_l_d = acc_l_q + ACC_W'(prod);
            if ((cur_pan == PAN_R) || (cur_pan == PAN_BOTH)) acc_r_d = acc_r_q + ACC_W'(prod);
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NUM_CH - 1)) state_d = SAT;
         end
         SAT: begin
            audio_l_d   = sat_l;
            audio_r_d   = sat_r;
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         acc_l_q     <= '0;
         acc_r_q     <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            snap_in_q[i]   <= '0;
            snap_gain_q[i] <= '0;
            snap_pan_q[i]  <= PAN_OFF;
         end
         audio_l_q   <= '0;
         audio_r_q   <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_l_q     <= acc_l_d;
         acc_r_q     <= acc_r_d;
         snap_in_q   <= snap_in_d;
         snap_gain_q <= snap_gain_d;
         snap_pan_q  <= snap_pan_d;
         audio_l_q   <= audio_l_d;
         audio_r_q   <= audio_r_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

`ifdef AUDIO_MIXER_CLIP_COUNT_EN
   logic [15:0] clip_cnt_q, clip_cnt_d;

   // One count per frame even when both sides clip; sticks at all-ones.
   always_comb begin
      clip_cnt_d = clip_cnt_q;
      if ((state_q == SAT) && (clip_l || clip_r) && (clip_cnt_q != 16'hFFFF))
         clip_cnt_d = clip_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) clip_cnt_q <= '0;
      else       clip_cnt_q <= clip_cnt_d;
   end

   assign clip_cnt = clip_cnt_q;
`else
   logic unused_clip;
   assign unused_clip = clip_l | clip_r;
   assign clip_cnt    = '0;
`endif

   assign audio_l   = audio_l_q;
   assign audio_r   = audio_r_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q != IDLE);
   assign overrun   = overrun_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer: vector table of frames plus hand-written
// sequences for overrun, SAT-cycle strobe, mid-frame reset and late input change.
module tb_audio_mixer;
   import audio_mixer_pkg::*;

   localparam int NUM_CH = 4;
   localparam int IN_W   = 16;
   localparam int OUT_W  = 16;
   localparam int GAIN_W = 4;

   logic                     clk_sys;
   logic                     reset;
   logic                     sample_ce;
   logic [NUM_CH*IN_W-1:0]   ch_in;
   logic [NUM_CH*GAIN_W-1:0] ch_gain;
   logic [NUM_CH*2-1:0]      ch_pan;
   logic [OUT_W-1:0]         audio_l, audio_r;
   logic                     out_valid, busy, overrun;
   logic [15:0]              clip_cnt;
   mix_state_e               dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_clip = 0;

   typedef struct {
      string       name;
      logic [63:0] in;
      logic [15:0] gain;
      logic [7:0]  pan;
      logic [15:0] exp_l;
      logic [15:0] exp_r;
      int          clip_inc;
   } vec_t;

   vec_t vecs[9];

   audio_mixer #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W)) dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .sample_ce(sample_ce),
      .ch_in    (ch_in),
      .ch_gain  (ch_gain),
      .ch_pan   (ch_pan),
      .audio_l  (audio_l),
      .audio_r  (audio_r),
      .out_valid(out_valid),
      .busy     (busy),
      .overrun  (overrun),
      .clip_cnt (clip_cnt),
      .dbg_state(dbg_state)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      exp_clip = 0;
   endtask

   task automatic add_clip(input int inc);
`ifdef AUDIO_MIXER_CLIP_COUNT_EN
      exp_clip += inc;
`else
      exp_clip += 0 * inc;
`endif
   endtask

   // Pulses sample_ce in cycle 0 and waits for out_valid; optionally scrambles inputs in cycle 1.
   task automatic run_frame(input string name, input logic [15:0] el, input logic [15:0] er,
                            input bit scramble);
      int cyc;
      sample_ce = 1'b1;
      step();
      sample_ce = 1'b0;
      cyc = 1;
      check({name, " busy"}, 32'(busy), 32'd1);
      if (scramble) begin
         ch_in   = '1;
         ch_gain = '1;
         ch_pan  = '1;
      end
      while (!out_valid && cyc < 20) begin
         step();
         cyc++;
      end
      check({name, " latency"}, 32'(cyc), 32'(NUM_CH + 2));
      check({name, " audio_l"}, 32'(audio_l), 32'(el));
      check({name, " audio_r"}, 32'(audio_r), 32'(er));
      check({name, " busy_done"}, 32'(busy), 32'd0);
      check({name, " clip_cnt"}, 32'(clip_cnt), 32'(exp_clip));
      step();
      check({name, " valid_pulse"}, 32'(out_valid), 32'd0);
      check({name, " hold_l"}, 32'(audio_l), 32'(el));
   endtask

   // Drives sample_ce from mask bit c during cycle c; records out_valid cycles.
   task automatic run_seq(input logic [31:0] mask, input int ncyc,
                          output int nvalid, output int first_v, output int last_v);
      nvalid  = 0;
      first_v = -1;
      last_v  = -1;
      for (int c = 0; c < ncyc; c++) begin
         sample_ce = mask[c];
         step();
         if (out_valid) begin
            nvalid++;
            if (first_v < 0) first_v = c + 1;
            last_v = c + 1;
         end
      end
      sample_ce = 1'b0;
   endtask

   task automatic load_unit();
      ch_in   = {16'd4000, 16'd3000, 16'd2000, 16'd1000};
      ch_gain = 16'h8888;
      ch_pan  = 8'hFF;
   endtask

   initial begin
      int nv, fv, lv;

      vecs[0] = '{"unit",      {16'd4000, 16'd3000, 16'd2000, 16'd1000}, 16'h8888, 8'hFF, 16'd10000, 16'd10000, 0};
      vecs[1] = '{"pan_mute",  {16'h7777, 16'h5555, 16'h4321, 16'h1234}, 16'h8088, 8'h39, 16'h1234, 16'h4321, 0};
      vecs[2] = '{"sat_all",   64'hFFFF_FFFF_FFFF_FFFF,                  16'hFFFF, 8'hFF, 16'hFFFF, 16'hFFFF, 1};
      vecs[3] = '{"gains",     {16'd7, 16'd8, 16'd200, 16'd100},         16'h31C4, 8'h6D, 16'd352,   16'd301,   0};
      vecs[4] = '{"clip_l",    {16'h0000, 16'h0010, 16'hFFFF, 16'hFFFF}, 16'h08FF, 8'h25, 16'hFFFF, 16'd16,    1};
      vecs[5] = '{"edge_max",  64'h0000_0000_0000_FFFF,                  16'h8888, 8'hFF, 16'hFFFF, 16'hFFFF, 0};
      vecs[6] = '{"edge_over", 64'h0000_0000_0001_FFFF,                  16'h8888, 8'hFF, 16'hFFFF, 16'hFFFF, 1};
      vecs[7] = '{"zeros",     64'h0,                                    16'hFFFF, 8'hFF, 16'd0,     16'd0,     0};
      vecs[8] = '{"trunc",     {16'd0, 16'd0, 16'd1, 16'd7},             16'h0011, 8'hFF, 16'd1,     16'd1,     0};

      reset     = 1'b1;
      sample_ce = 1'b0;
      ch_in     = '0;
      ch_gain   = '0;
      ch_pan    = '0;
      step();
      step();
      step();
      reset = 1'b0;
      check("rst audio_l", 32'(audio_l), 32'd0);
      check("rst audio_r", 32'(audio_r), 32'd0);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst overrun", 32'(overrun), 32'd0);
      check("rst clip_cnt", 32'(clip_cnt), 32'd0);
      check("rst state", 32'(dbg_state), 32'(IDLE));

      for (int i = 0; i < 9; i++) begin
         ch_in   = vecs[i].in;
         ch_gain = vecs[i].gain;
         ch_pan  = vecs[i].pan;
         add_clip(vecs[i].clip_inc);
         run_frame(vecs[i].name, vecs[i].exp_l, vecs[i].exp_r, 1'b0);
      end
      check("overrun quiet", 32'(overrun), 32'd0);

      // Inputs changing right after the latch cycle must not affect the frame.
      load_unit();
      run_frame("late_change", 16'd10000, 16'd10000, 1'b1);

      // Strobe during the SAT cycle is dropped and flags overrun.
      do_reset();
      load_unit();
      run_seq(32'h0000_0021, 12, nv, fv, lv);
      check("satce nvalid", 32'(nv), 32'd1);
      check("satce first", 32'(fv), 32'd6);
      check("satce audio_l", 32'(audio_l), 32'd10000);
      check("satce overrun", 32'(overrun), 32'd1);
      do_reset();
      check("overrun cleared", 32'(overrun), 32'd0);

      // Strobe mid-frame is dropped; strobe in the out_valid cycle is accepted.
      load_unit();
      run_seq(32'h0000_0049, 14, nv, fv, lv);
      check("ovr nvalid", 32'(nv), 32'd2);
      check("ovr first", 32'(fv), 32'd6);
      check("ovr second", 32'(lv), 32'd12);
      check("ovr overrun", 32'(overrun), 32'd1);
      ch_in = {16'd0, 16'd0, 16'd0, 16'd800};
      run_frame("ovr_after", 16'd800, 16'd800, 1'b0);
      check("ovr sticky", 32'(overrun), 32'd1);

      // Reset in cycle 3 aborts the frame silently.
      load_unit();
      sample_ce = 1'b1;
      step();
      sample_ce = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_clip = 0;
      nv = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid) nv++;
         step();
      end
      check("midrst nvalid", 32'(nv), 32'd0);
      check("midrst audio_l", 32'(audio_l), 32'd0);
      check("midrst audio_r", 32'(audio_r), 32'd0);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst overrun", 32'(overrun), 32'd0);
      check("midrst clip_cnt", 32'(clip_cnt), 32'd0);
      run_frame("after_rst", 16'd10000, 16'd10000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
